// File: rtl/adex_param_streamer_if.sv
// rtl/adex_param_streamer_if.sv - host/loader signal bundle for the AdEx parameter streamer
//
// master: host/config side (drives start, abort, parameter bytes; observes status and loader pins)
// slave : streamer side (samples request and bytes; drives loader pins, busy, done)
//   start, abort          request / cancel
//   p_delta_t .. p_ibias  seven parameter bytes
//   load_mode             loader ui_in[4]
//   load_enable           loader ui_in[3]
//   nibble[3:0]           loader uio_in[3:0]
//   busy, done            stream status

interface adex_param_streamer_if;
    logic       start;
    logic       abort;
    logic [7:0] p_delta_t;
    logic [7:0] p_tau_w;
    logic [7:0] p_a;
    logic [7:0] p_b;
    logic [7:0] p_vreset;
    logic [7:0] p_vt;
    logic [7:0] p_ibias;
    logic       load_mode;
    logic       load_enable;
    logic [3:0] nibble;
    logic       busy;
    logic       done;

    modport master (
        output start, abort,
        output p_delta_t, p_tau_w, p_a, p_b, p_vreset, p_vt, p_ibias,
        input  load_mode, load_enable, nibble, busy, done
    );

    modport slave (
        input  start, abort,
        input  p_delta_t, p_tau_w, p_a, p_b, p_vreset, p_vt, p_ibias,
        output load_mode, load_enable, nibble, busy, done
    );
endinterface

// File: rtl/adex_param_streamer.sv
// rtl/adex_param_streamer.sv - drives the AdEx nibble loader with a 16-item parameter stream
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    adex_param_streamer_if.slave
//            in : start, abort, p_delta_t, p_tau_w, p_a, p_b, p_vreset, p_vt, p_ibias
//            out: load_mode, load_enable, nibble[3:0], busy, done (all registered)
//
// Parameters (cycle counts, 1..255; LOW_CYC must be at least 2 so no edge lands
// in the loader's byte-latch cycle): SETUP_CYC, HIGH_CYC, LOW_CYC, RELEASE_CYC.

module adex_param_streamer #(
    parameter int SETUP_CYC   = 2,
    parameter int HIGH_CYC    = 2,
    parameter int LOW_CYC     = 2,
    parameter int RELEASE_CYC = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    adex_param_streamer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE_H,
        PULSE_L,
        RELEASE,
        DONE
    } state_t;

    // Phase counter reload values: the counter runs N-1 .. 0 so a phase lasts N cycles.
    localparam logic [7:0] SETUP_RL   = 8'(SETUP_CYC - 1);
    localparam logic [7:0] HIGH_RL    = 8'(HIGH_CYC - 1);
    localparam logic [7:0] LOW_RL     = 8'(LOW_CYC - 1);
    localparam logic [7:0] RELEASE_RL = 8'(RELEASE_CYC - 1);

    state_t      state;
    logic [7:0]  phase_cnt;
    logic [3:0]  item;
    logic [55:0] shadow;   // {DeltaT, TauW, a, b, Vreset, VT, Ibias}, DeltaT in the top byte

    // Item 0 is the start edge, 1..14 walk the shadow register from the top
    // nibble down, 15 is the footer.
    function automatic logic [3:0] item_nibble(input logic [3:0] idx, input logic [55:0] sh);
        logic [5:0]  sh_amt;
        logic [55:0] shifted;
        sh_amt  = {4'd14 - idx, 2'b00};
        shifted = sh >> sh_amt;
        if (idx == 4'd0)
            item_nibble = 4'h0;
        else if (idx == 4'd15)
            item_nibble = 4'hF;
        else
            item_nibble = shifted[3:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            phase_cnt       <= 8'd0;
            item            <= 4'd0;
            shadow          <= 56'd0;
            bus.load_mode   <= 1'b0;
            bus.load_enable <= 1'b0;
            bus.nibble      <= 4'h0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else if (bus.abort) begin
            // Dropping load_mode returns the loader to idle without a commit.
            // In IDLE this also swallows a simultaneous start.
            state           <= IDLE;
            phase_cnt       <= 8'd0;
            item            <= 4'd0;
            bus.load_mode   <= 1'b0;
            bus.load_enable <= 1'b0;
            bus.nibble      <= 4'h0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shadow        <= {bus.p_delta_t, bus.p_tau_w, bus.p_a, bus.p_b,
                                          bus.p_vreset, bus.p_vt, bus.p_ibias};
                        state         <= SETUP;
                        phase_cnt     <= SETUP_RL;
                        bus.load_mode <= 1'b1;
                        bus.busy      <= 1'b1;
                    end
                end

                SETUP: begin
                    if (phase_cnt == 8'd0) begin
                        state           <= PULSE_H;
                        item            <= 4'd0;
                        phase_cnt       <= HIGH_RL;
                        bus.load_enable <= 1'b1;
                        bus.nibble      <= item_nibble(4'd0, shadow);
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end

                PULSE_H: begin
                    if (phase_cnt == 8'd0) begin
                        state           <= PULSE_L;
                        phase_cnt       <= LOW_RL;
                        bus.load_enable <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end

                PULSE_L: begin
                    if (phase_cnt == 8'd0) begin
                        if (item != 4'd15) begin
                            // nibble moves only together with the rising load_enable
                            item            <= item + 4'd1;
                            state           <= PULSE_H;
                            phase_cnt       <= HIGH_RL;
                            bus.load_enable <= 1'b1;
                            bus.nibble      <= item_nibble(item + 4'd1, shadow);
                        end else begin
                            state     <= RELEASE;
                            phase_cnt <= RELEASE_RL;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end

                RELEASE: begin
                    // load_mode held high here so the loader can present params_ready
                    if (phase_cnt == 8'd0) begin
                        state         <= DONE;
                        phase_cnt     <= 8'd0;
                        bus.load_mode <= 1'b0;
                        bus.nibble    <= 4'h0;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                end

                default: begin
                    state           <= IDLE;
                    bus.load_mode   <= 1'b0;
                    bus.load_enable <= 1'b0;
                    bus.nibble      <= 4'h0;
                    bus.busy        <= 1'b0;
                    bus.done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adex_param_streamer.sv
// tb/tb_adex_param_streamer.sv - directed bench for adex_param_streamer with a nibble loader model

module tb_adex_param_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sel   = 1'b0;
    logic [7:0] pd = 8'h0, pt = 8'h0, pa = 8'h0, pb = 8'h0, pv = 8'h0, pvt = 8'h0, pi = 8'h0;

    int total = 0;
    int bad   = 0;

    adex_param_streamer_if bus0 ();
    adex_param_streamer_if bus1 ();

    assign bus0.start = start & ~sel;
    assign bus0.abort = abort & ~sel;
    assign bus1.start = start & sel;
    assign bus1.abort = abort & sel;
    assign bus0.p_delta_t = pd;  assign bus1.p_delta_t = pd;
    assign bus0.p_tau_w   = pt;  assign bus1.p_tau_w   = pt;
    assign bus0.p_a       = pa;  assign bus1.p_a       = pa;
    assign bus0.p_b       = pb;  assign bus1.p_b       = pb;
    assign bus0.p_vreset  = pv;  assign bus1.p_vreset  = pv;
    assign bus0.p_vt      = pvt; assign bus1.p_vt      = pvt;
    assign bus0.p_ibias   = pi;  assign bus1.p_ibias   = pi;

    adex_param_streamer dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    adex_param_streamer #(
        .SETUP_CYC   (1),
        .HIGH_CYC    (1),
        .LOW_CYC     (2),
        .RELEASE_CYC (1)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    wire       m_mode = sel ? bus1.load_mode   : bus0.load_mode;
    wire       m_en   = sel ? bus1.load_enable : bus0.load_enable;
    wire [3:0] m_nib  = sel ? bus1.nibble      : bus0.nibble;
    wire       m_done = sel ? bus1.done        : bus0.done;

    logic [3:0] exp_nib   [16] = '{4'h0, 4'h8, 4'h2, 4'h6, 4'h4, 4'h0, 4'h2, 4'h2,
                                   4'h8, 4'h3, 4'hF, 4'h4, 4'hE, 4'h9, 4'h0, 4'hF};
    logic [7:0] exp_bytes [7]  = '{8'h82, 8'h64, 8'h02, 8'h28, 8'h3F, 8'h4E, 8'h90};

    // ---------------- pin monitor ----------------
    int         mon_cyc   = 0;
    int         rise_cyc[$];
    logic [3:0] nib_q[$];
    int         hi_q[$];
    int         hi_cnt    = 0;
    int         done_cnt  = 0;
    int         done_cyc  = 0;
    int         mode_rise = 0;
    int         glitch    = 0;
    logic       prev_en   = 1'b0;
    logic       prev_mode = 1'b0;
    logic [3:0] prev_nib  = 4'h0;

    always @(posedge clk) begin
        mon_cyc   <= mon_cyc + 1;
        prev_en   <= m_en;
        prev_mode <= m_mode;
        prev_nib  <= m_nib;
        if (m_mode && !prev_mode) mode_rise <= mon_cyc;
        if (m_en && !prev_en) begin
            rise_cyc.push_back(mon_cyc);
            nib_q.push_back(m_nib);
        end
        if (m_en) hi_cnt <= hi_cnt + 1;
        else if (prev_en) begin
            hi_q.push_back(hi_cnt);
            hi_cnt <= 0;
        end
        if (m_mode && prev_mode && (m_nib !== prev_nib) && !(m_en && !prev_en)) glitch <= glitch + 1;
        if (m_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= mon_cyc;
        end
    end

    // ---------------- loader model ----------------
    int         ld_count     = 0;
    logic [3:0] hi_nib       = 4'h0;
    logic [7:0] stage  [7]   = '{default: 8'h00};
    logic [7:0] r_regs [7]   = '{default: 8'h00};
    logic       r_ready      = 1'b0;
    logic       latch_cyc    = 1'b0;
    int         viol         = 0;
    int         commits      = 0;
    int         ready_cycles = 0;

    always @(posedge clk) begin
        if (!m_mode) begin
            ld_count  <= 0;
            r_ready   <= 1'b0;
            latch_cyc <= 1'b0;
        end else begin
            latch_cyc <= 1'b0;
            if (m_en && !prev_en) begin
                if (latch_cyc) viol <= viol + 1;
                else if (ld_count == 0) ld_count <= 1;
                else if (ld_count <= 14) begin
                    if (ld_count[0]) hi_nib <= m_nib;
                    else begin
                        stage[3'((ld_count - 2) / 2)] <= {hi_nib, m_nib};
                        latch_cyc <= 1'b1;
                    end
                    ld_count <= ld_count + 1;
                end else if (ld_count == 15 && m_nib == 4'hF) begin
                    r_regs   <= stage;
                    r_ready  <= 1'b1;
                    commits  <= commits + 1;
                    ld_count <= 16;
                end
            end
        end
        if (r_ready && m_mode) ready_cycles <= ready_cycles + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_default_params();
        pd = 8'h82; pt = 8'h64; pa = 8'h02; pb = 8'h28; pv = 8'h3F; pvt = 8'h4E; pi = 8'h90;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        int d0;
        d0 = done_cnt;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({bus0.load_mode, bus0.load_enable, bus0.nibble, bus0.busy, bus0.done} !== 8'h00) begin
            bad++; $display("FAIL reset_outputs: got %b want 00000000",
                {bus0.load_mode, bus0.load_enable, bus0.nibble, bus0.busy, bus0.done});
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({bus0.load_mode, bus0.load_enable, bus0.nibble, bus0.busy, bus0.done} !== 8'h00) begin
            bad++; $display("FAIL post_reset_outputs: got %b want 00000000",
                {bus0.load_mode, bus0.load_enable, bus0.nibble, bus0.busy, bus0.done});
        end
    endtask

    task automatic test_default_stream();
        int n0, h0, d0, c0, rc0, g0, v0;
        bit to;
        sel = 1'b0;
        set_default_params();
        n0 = nib_q.size(); h0 = hi_q.size(); d0 = done_cnt; c0 = commits;
        rc0 = ready_cycles; g0 = glitch; v0 = viol;
        pulse_start();
        total++;
        if (bus0.busy !== 1'b1) begin bad++; $display("FAIL default_busy: got %b want 1", bus0.busy); end
        wait_done(200, to);
        total++;
        if (to) begin bad++; $display("FAIL default_timeout: no done within 200 cycles"); end
        total++;
        if (nib_q.size() - n0 != 16) begin bad++; $display("FAIL default_pulses: got %0d want 16", nib_q.size() - n0); end
        for (int k = 0; k < 16; k++) begin
            logic [3:0] got;
            got = (n0 + k < nib_q.size()) ? nib_q[n0 + k] : 4'hx;
            total++;
            if (got !== exp_nib[k]) begin bad++; $display("FAIL default_nibble[%0d]: got %h want %h", k, got, exp_nib[k]); end
        end
        for (int k = 0; k < 16; k++) begin
            int got;
            got = (h0 + k < hi_q.size()) ? hi_q[h0 + k] : -1;
            total++;
            if (got != 2) begin bad++; $display("FAIL default_high_len[%0d]: got %0d want 2", k, got); end
        end
        for (int k = 0; k < 15; k++) begin
            int got;
            got = (n0 + k + 1 < rise_cyc.size()) ? rise_cyc[n0 + k + 1] - rise_cyc[n0 + k] : -1;
            total++;
            if (got != 4) begin bad++; $display("FAIL default_period[%0d]: got %0d want 4", k, got); end
        end
        total++;
        if (done_cyc - mode_rise != 68) begin bad++; $display("FAIL default_total_cycles: got %0d want 68", done_cyc - mode_rise); end
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL default_done_count: got %0d want 1", done_cnt - d0); end
        total++;
        if ({bus0.done, bus0.busy, bus0.load_mode} !== 3'b000) begin
            bad++; $display("FAIL default_after_done: got %b want 000", {bus0.done, bus0.busy, bus0.load_mode});
        end
        total++;
        if (glitch != g0) begin bad++; $display("FAIL default_nibble_stable: got %0d changes want 0", glitch - g0); end
        total++;
        if (commits - c0 != 1) begin bad++; $display("FAIL default_commit: got %0d want 1", commits - c0); end
        total++;
        if (ready_cycles == rc0) begin bad++; $display("FAIL default_ready: got 0 ready cycles want >0"); end
        total++;
        if (viol != v0) begin bad++; $display("FAIL default_latch_edge: got %0d want 0", viol - v0); end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (r_regs[i] !== exp_bytes[i]) begin bad++; $display("FAIL default_reg[%0d]: got %h want %h", i, r_regs[i], exp_bytes[i]); end
        end
    endtask

    task automatic test_busy_restart();
        int n0, d0;
        bit to;
        sel = 1'b0;
        set_default_params();
        n0 = nib_q.size(); d0 = done_cnt;
        pulse_start();
        repeat (9) @(negedge clk);
        pd = 8'hFF; pt = 8'hFF; pa = 8'hFF; pb = 8'hFF; pv = 8'hFF; pvt = 8'hFF; pi = 8'hFF;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(200, to);
        total++;
        if (to) begin bad++; $display("FAIL restart_timeout: no done within 200 cycles"); end
        for (int k = 0; k < 16; k++) begin
            logic [3:0] got;
            got = (n0 + k < nib_q.size()) ? nib_q[n0 + k] : 4'hx;
            total++;
            if (got !== exp_nib[k]) begin bad++; $display("FAIL restart_nibble[%0d]: got %h want %h", k, got, exp_nib[k]); end
        end
        repeat (6) @(negedge clk);
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL restart_done_count: got %0d want 1", done_cnt - d0); end
        total++;
        if ({bus0.busy, bus0.load_mode} !== 2'b00) begin bad++; $display("FAIL restart_idle: got %b want 00", {bus0.busy, bus0.load_mode}); end
        set_default_params();
    endtask

    task automatic test_abort();
        int n0, d0, c0;
        bit seen;
        sel = 1'b0;
        set_default_params();
        n0 = nib_q.size(); d0 = done_cnt; c0 = commits;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (nib_q.size() - n0 >= 8) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        total++;
        if (!seen) begin bad++; $display("FAIL abort_reach_item7: got %0d pulses want 8", nib_q.size() - n0); end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        total++;
        if ({bus0.load_mode, bus0.load_enable, bus0.nibble, bus0.busy, bus0.done} !== 8'h00) begin
            bad++; $display("FAIL abort_outputs: got %b want 00000000",
                {bus0.load_mode, bus0.load_enable, bus0.nibble, bus0.busy, bus0.done});
        end
        repeat (6) @(negedge clk);
        total++;
        if (done_cnt != d0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0); end
        total++;
        if (commits != c0) begin bad++; $display("FAIL abort_no_commit: got %0d want 0", commits - c0); end
        total++;
        if ({r_ready, bus0.busy} !== 2'b00) begin bad++; $display("FAIL abort_idle: got %b want 00", {r_ready, bus0.busy}); end
    endtask

    task automatic test_reset_mid_stream();
        int n0, n1, d0, c0;
        bit seen, to;
        sel = 1'b0;
        set_default_params();
        n0 = nib_q.size(); c0 = commits;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (nib_q.size() - n0 >= 13 && bus0.load_enable) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        total++;
        if (!seen) begin bad++; $display("FAIL midreset_reach_item12: got %0d pulses want 13", nib_q.size() - n0); end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({bus0.load_mode, bus0.load_enable, bus0.nibble, bus0.busy, bus0.done} !== 8'h00) begin
            bad++; $display("FAIL midreset_outputs: got %b want 00000000",
                {bus0.load_mode, bus0.load_enable, bus0.nibble, bus0.busy, bus0.done});
        end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        total++;
        if ({bus0.load_mode, bus0.busy, commits - c0} !== {2'b00, 32'd0}) begin
            bad++; $display("FAIL midreset_released: got mode/busy %b commits %0d want 00 and 0",
                {bus0.load_mode, bus0.busy}, commits - c0);
        end
        n1 = nib_q.size(); d0 = done_cnt;
        pulse_start();
        wait_done(200, to);
        total++;
        if (to) begin bad++; $display("FAIL midreset_timeout: no done within 200 cycles"); end
        for (int k = 0; k < 16; k++) begin
            logic [3:0] got;
            got = (n1 + k < nib_q.size()) ? nib_q[n1 + k] : 4'hx;
            total++;
            if (got !== exp_nib[k]) begin bad++; $display("FAIL midreset_nibble[%0d]: got %h want %h", k, got, exp_nib[k]); end
        end
        total++;
        if (commits - c0 != 1) begin bad++; $display("FAIL midreset_commit: got %0d want 1", commits - c0); end
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL midreset_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_override_params();
        int n0, h0, d0, c0, v0;
        bit to;
        repeat (2) @(negedge clk);
        sel = 1'b1;
        set_default_params();
        @(negedge clk);
        n0 = nib_q.size(); h0 = hi_q.size(); d0 = done_cnt; c0 = commits; v0 = viol;
        pulse_start();
        total++;
        if (bus1.busy !== 1'b1) begin bad++; $display("FAIL override_busy: got %b want 1", bus1.busy); end
        wait_done(200, to);
        total++;
        if (to) begin bad++; $display("FAIL override_timeout: no done within 200 cycles"); end
        for (int k = 0; k < 16; k++) begin
            logic [3:0] got;
            got = (n0 + k < nib_q.size()) ? nib_q[n0 + k] : 4'hx;
            total++;
            if (got !== exp_nib[k]) begin bad++; $display("FAIL override_nibble[%0d]: got %h want %h", k, got, exp_nib[k]); end
        end
        for (int k = 0; k < 16; k++) begin
            int got;
            got = (h0 + k < hi_q.size()) ? hi_q[h0 + k] : -1;
            total++;
            if (got != 1) begin bad++; $display("FAIL override_high_len[%0d]: got %0d want 1", k, got); end
        end
        for (int k = 0; k < 15; k++) begin
            int got;
            got = (n0 + k + 1 < rise_cyc.size()) ? rise_cyc[n0 + k + 1] - rise_cyc[n0 + k] : -1;
            total++;
            if (got != 3) begin bad++; $display("FAIL override_period[%0d]: got %0d want 3", k, got); end
        end
        total++;
        if (done_cyc - mode_rise != 50) begin bad++; $display("FAIL override_total_cycles: got %0d want 50", done_cyc - mode_rise); end
        total++;
        if (commits - c0 != 1) begin bad++; $display("FAIL override_commit: got %0d want 1", commits - c0); end
        total++;
        if (viol != v0) begin bad++; $display("FAIL override_latch_edge: got %0d want 0", viol - v0); end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (r_regs[i] !== exp_bytes[i]) begin bad++; $display("FAIL override_reg[%0d]: got %h want %h", i, r_regs[i], exp_bytes[i]); end
        end
        // start and abort together in IDLE
        d0 = done_cnt;
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        total++;
        if ({bus1.load_mode, bus1.load_enable, bus1.nibble, bus1.busy, bus1.done} !== 8'h00) begin
            bad++; $display("FAIL start_abort_outputs: got %b want 00000000",
                {bus1.load_mode, bus1.load_enable, bus1.nibble, bus1.busy, bus1.done});
        end
        repeat (4) @(negedge clk);
        total++;
        if ({bus1.busy, bus1.load_mode} !== 2'b00 || done_cnt != d0) begin
            bad++; $display("FAIL start_abort_idle: got busy/mode %b dones %0d want 00 and 0",
                {bus1.busy, bus1.load_mode}, done_cnt - d0);
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_stream();
        test_busy_restart();
        test_abort();
        test_reset_mid_stream();
        test_override_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adex_param_streamer.md
Name: adex_param_streamer

Overview:
- Upstream driver for the AdEx neuron's nibble-based parameter loader.
- Takes seven 8-bit parameter bytes plus a start strobe and generates the complete load sequence on the loader's pins: load_mode, load_enable pulses, a 4-bit nibble bus and the 0xF footer.
- Sits between the host/config logic (or an on-chip default ROM) and the neuron's ui_in[4:3] / uio_in[3:0] inputs.
- Pulse spacing is set by parameters so the loader's edge detector and its one-cycle byte-latch state never miss an edge.

Parameters:
- SETUP_CYC, 2: cycles load_mode is high with load_enable low before the first edge; range 1..255.
- HIGH_CYC, 2: cycles load_enable is high per pulse; range 1..255.
- LOW_CYC, 2: cycles load_enable is low after each pulse; range 2..255. A value below 2 is illegal, because the loader ignores edges during its latch cycle.
- RELEASE_CYC, 2: cycles load_mode stays high after the footer pulse's low phase; range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to stream; honoured only in IDLE
- abort  in  1  cancel the stream in progress
- p_delta_t  in  8  DeltaT byte
- p_tau_w  in  8  TauW byte
- p_a  in  8  a byte
- p_b  in  8  b byte
- p_vreset  in  8  Vreset byte
- p_vt  in  8  VT byte
- p_ibias  in  8  Ibias byte
- load_mode  out  1  drives loader ui_in[4]
- load_enable  out  1  drives loader ui_in[3]
- nibble  out  4  drives loader uio_in[3:0]
- busy  out  1  high from the cycle after start is accepted until the return to IDLE
- done  out  1  one-cycle pulse on successful completion

Behaviour:
- All outputs are registered. While reset is high and in the cycle after reset releases, every output is 0.
- Start:
  - start is honoured only in IDLE.
  - On acceptance, latch all seven bytes into a 56-bit shadow register. Input changes after acceptance have no effect on the stream in progress.
  - start while busy is ignored.
- Item stream: 16 items, indexed 0..15, one load_enable pulse per item.
  - Item 0: start edge, nibble=0.
  - Items 1..14: parameter nibbles. Byte order is DeltaT, TauW, a, b, Vreset, VT, Ibias; high nibble before low nibble.
  - Item 15: footer, nibble=4'hF.
- nibble changes only in the same cycle load_enable rises, and holds through the HIGH and LOW phases of that item.
- FSM states: IDLE, SETUP, PULSE_H, PULSE_L, RELEASE, DONE.
  - IDLE: all outputs 0. start → SETUP.
  - SETUP: load_mode=1, load_enable=0 for SETUP_CYC cycles → PULSE_H with item=0.
  - PULSE_H: load_enable=1 for HIGH_CYC cycles → PULSE_L.
  - PULSE_L: load_enable=0 for LOW_CYC cycles. If item<15: item++ → PULSE_H. Else → RELEASE.
  - RELEASE: load_mode=1 for RELEASE_CYC cycles → DONE.
  - DONE: load_mode=0, done=1, busy=0 for one cycle → IDLE.
- busy is 1 in SETUP, PULSE_H, PULSE_L and RELEASE.
- Total cycles from the first load_mode=1 cycle to the done cycle, exclusive of done: SETUP_CYC + 16*(HIGH_CYC+LOW_CYC) + RELEASE_CYC. With defaults this is 68.
- Phase counter: 8-bit down-counter, reloaded to N-1 on every state entry; transition when it reaches 0. Item counter is 4 bits.
- abort: in any non-IDLE state, the next cycle goes to IDLE with load_mode=0, load_enable=0, nibble=0, busy=0 and no done pulse. This deliberately drops the loader back to its idle state without committing any parameters.
- start and abort together in IDLE: abort wins and start is dropped.
- reset mid-stream: same output result as abort; the shadow register clears to 0.
- Result at the loader: with the defaults, the loader commits all seven bytes and asserts params_ready while load_mode is high in RELEASE. When load_mode falls, params_ready deasserts; the neuron core retains the copied values.

Test Plan:
- Default stream with DeltaT=0x82, TauW=0x64, a=0x02, b=0x28, Vreset=0x3F, VT=0x4E, Ibias=0x90, start pulsed → nibble sampled at each load_enable rise = 0,8,2,6,4,0,2,2,8,3,F,4,E,9,0,F. Exactly 16 pulses, each 2 cycles high and 2 low. done occurs 68 cycles after load_mode first rises.
- Same stream connected to the neuron loader model → r_ready=1 during RELEASE and r_* registers equal the seven bytes. Also check the loader never sees an edge during its latch cycle.
- Change every p_* input to 0xFF and pulse start again while busy, 10 cycles after acceptance → nibble sequence unchanged, second start ignored, exactly one done.
- Assert abort during item 7 → next cycle all outputs 0 and busy=0, no done pulse. The loader stays not-ready and does not commit values.
- Assert reset in PULSE_H of item 12, then start again after reset releases → clean full 16-item stream with correct nibbles.
- Parameter override HIGH_CYC=1, LOW_CYC=2, SETUP_CYC=1, RELEASE_CYC=1 → total 50 cycles and correct loader commit. Assert start and abort together in IDLE → remains IDLE.
